// File: rtl/instr_encoder_loader_if.sv
// Field-set stream into the loader plus the instruction-memory write port.
// master = producer/memory side, slave = the loader itself.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 12
);
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm;

    logic              imem_we;
    logic              imem_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_last, opcode, rd, rs1, rs2, funct3, funct7, imm,
        input  in_ready,
        output imem_ready,
        input  imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_last, opcode, rd, rs1, rs2, funct3, funct7, imm,
        output in_ready,
        input  imem_ready,
        output imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs RV32I field sets into instruction words and writes them to consecutive imem addresses.
// Latency 1 cycle accept->imem_we; 1-deep output register, in_ready drops while a write is stalled.
module instr_encoder_loader #(
    parameter int          ADDR_W   = 12,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    instr_encoder_loader_if.slave bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [7:0]           err_count,
    output logic [ADDR_W-1:0]    word_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t      state;
    logic [31:0] enc_word;
    logic        enc_ok;
    logic        imm12_ok;
    logic        imm13_ok;
    logic        imm21_ok;
    logic        accept;
    logic        wr_done;

    // Signed range checks: every bit above the field's sign bit must equal it.
    assign imm12_ok = (&bus.imm[31:11]) || !(|bus.imm[31:11]);
    assign imm13_ok = (&bus.imm[31:12]) || !(|bus.imm[31:12]);
    assign imm21_ok = (&bus.imm[31:20]) || !(|bus.imm[31:20]);

    always_comb begin
        enc_word = NOP_WORD;
        enc_ok   = 1'b0;
        case (bus.opcode)
            7'h03, 7'h13, 7'h1b, 7'h67: begin
                enc_ok   = imm12_ok;
                enc_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
            end
            7'h23: begin
                enc_ok   = imm12_ok;
                enc_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
            end
            7'h33, 7'h3b: begin
                enc_ok   = 1'b1;
                enc_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
            end
            7'h17, 7'h37: begin
                enc_ok   = (bus.imm[11:0] == 12'h000);
                enc_word = {bus.imm[31:12], bus.rd, bus.opcode};
            end
            7'h63: begin
                enc_ok   = imm13_ok && !bus.imm[0];
                enc_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                            bus.imm[4:1], bus.imm[11], bus.opcode};
            end
            7'h6f: begin
                enc_ok   = imm21_ok && !bus.imm[0];
                enc_word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                            bus.rd, bus.opcode};
            end
            default: ;
        endcase
        if (!enc_ok) begin
            enc_word = NOP_WORD;
        end
    end

    assign bus.in_ready = (state == S_RUN) && (!bus.imem_we || bus.imem_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign wr_done      = bus.imem_we && bus.imem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            err_count      <= '0;
            word_count     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state         <= S_RUN;
                        busy          <= 1'b1;
                        bus.imem_addr <= base_addr & ~ADDR_W'(3);
                        err           <= 1'b0;
                        err_count     <= '0;
                        word_count    <= '0;
                    end
                end
                S_RUN, S_DRAIN: begin
                    if (wr_done) begin
                        bus.imem_we   <= 1'b0;
                        bus.imem_addr <= bus.imem_addr + ADDR_W'(4);
                        word_count    <= word_count + ADDR_W'(1);
                    end
                    // An accept in the same cycle as a completing write refills the register.
                    if (accept) begin
                        bus.imem_we    <= 1'b1;
                        bus.imem_wdata <= enc_word;
                        if (!enc_ok) begin
                            err <= 1'b1;
                            if (err_count != 8'hFF) begin
                                err_count <= err_count + 8'd1;
                            end
                        end
                        if (bus.in_last) begin
                            state <= S_DRAIN;
                        end
                    end
                    if ((state == S_DRAIN) && wr_done) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the instruction decoder: takes decoded RV32I field sets (opcode, rd, funct3, funct7, rs1, rs2, imm) and packs each into a 32-bit instruction word.
- Streams encoded words into instruction memory at consecutive word addresses under a valid/ready handshake.
- Used as the boot/program loader and as the stimulus source that feeds known-good words to the decoder bench.

Parameters:
- ADDR_W, 12: byte-address width of instruction memory; the address wraps modulo 2^ADDR_W.
- NOP_WORD, 32'h00000013: word written in place of any field set that fails encoding.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load session at base_addr.
- base_addr  input  ADDR_W  first byte address; bits [1:0] are ignored (forced to 0).
- in_valid  input  1  field set present.
- in_ready  output  1  field set accepted when in_valid && in_ready.
- in_last  input  1  marks the final field set of the session.
- opcode  input  7  instruction opcode.
- rd, rs1, rs2  input  5 each  register indices.
- funct3  input  3  function field.
- funct7  input  7  function field (R-type only).
- imm  input  32  full-width signed immediate, in the same form the decoder produces.
- imem_we  output  1  write request; held until imem_ready.
- imem_ready  input  1  memory accepts the write this cycle.
- imem_addr  output  ADDR_W  write byte address.
- imem_wdata  output  32  encoded instruction.
- busy  output  1  session active (RUN or DRAIN).
- done  output  1  one-cycle pulse after the last word is written.
- err  output  1  sticky; set on any encode failure; cleared by start or reset.
- err_count  output  8  encode failures this session; saturates at 255.
- word_count  output  ADDR_W  words written this session.

Behaviour:
Reset:
- Async reset returns state to IDLE.
- imem_we=0, imem_addr=0, imem_wdata=0, in_ready=0, busy=0, done=0, err=0, err_count=0, word_count=0.
- A pending word is dropped and never written.

States:
- IDLE: start loads imem_addr=base_addr&~3, clears err, err_count and word_count, then goes to RUN.
- RUN: accepts field sets. Accepting one with in_last=1 goes to DRAIN.
- DRAIN: waits for the last word to be written, then pulses done for exactly 1 cycle and returns to IDLE.
- start outside IDLE is ignored.

Handshake:
- in_ready = (state==RUN) && (!imem_we || imem_ready). This is a 1-deep output register with pass-through on drain.
- Accept at edge N: imem_wdata and imem_we are valid from edge N (1-cycle latency).
- imem_we, imem_addr and imem_wdata hold stable while imem_ready=0.
- On imem_we && imem_ready: imem_addr += 4 (wraps), word_count += 1.
- Back-to-back accepts at 1 word/cycle when imem_ready stays 1.

Encoding:
- I-type (0x03, 0x13, 0x1b, 0x67): {imm[11:0], rs1, funct3, rd, opcode}. imm must lie in [-2048, 2047].
- S-type (0x23): {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}. Same range as I-type.
- R-type (0x33, 0x3b): {funct7, rs2, rs1, funct3, rd, opcode}.
- U-type (0x17, 0x37): {imm[31:12], rd, opcode}. imm[11:0] must be 0.
- B-type (0x63): {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}. imm must be even and lie in [-4096, 4094].
- J-type (0x6f): {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}. imm must be even and lie in [-2^20, 2^20-2].
- Encode failure (any other opcode, or a range/alignment violation): write NOP_WORD at the same address, set err, increment err_count (saturating). Loading continues.

Boundary conditions:
- Address wrap: base_addr = 2^ADDR_W-4, second word goes to address 0.
- in_last on the first field set: one write, then done.
- Reset asserted mid-session: the session is abandoned and done never pulses.

Test Plan:
- start with base_addr=0x100, then addi x1,x0,5 (op 0x13, rd=1, imm=5) with in_last=1 -> write 0x00500093 @0x100; done pulses 1 cycle after the write handshake; word_count=1.
- lui x2,0x12345 (imm=0x12345000), then jal x1,+8 (imm=8, in_last=1) -> writes 0x12345137 @0x0 and 0x008000EF @0x4.
- beq x1,x2,-4 (op 0x63, rs1=1, rs2=2, imm=-4) -> 0xFE208EE3. Round-trip through the decoder returns rs1=1, rs2=2, imm=0xFFFFFFFC.
- Failure cases: opcode 0x7F, then addi with imm=4096 -> two writes of 0x00000013; err=1; err_count=2. Next start clears err to 0.
- Backpressure: hold imem_ready=0 for 3 cycles with in_valid=1 -> in_ready=0; imem_we, imem_addr and imem_wdata stable; no word lost or duplicated.
- Session edges: base_addr=0xFFC with ADDR_W=12 -> second word @0x000. Assert rst_n=0 during RUN -> all outputs at reset values within the same cycle, no done pulse.
